// File: rtl/sms4_lin_iter.sv
// Iterative SMS4 linear transform L(B) = B ^ B<<<2 ^ B<<<10 ^ B<<<18 ^ B<<<24, one rotation per cycle.
// Optional macro SMS4_LIN_KEY_EN adds key_mode selecting L'(B) = B ^ B<<<13 ^ B<<<23.
module sms4_lin_iter #(
  parameter int BWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [0:BWIDTH-1] lin_in,
  input  logic              in_valid,
  output logic              in_ready,
`ifdef SMS4_LIN_KEY_EN
  input  logic              key_mode,
`endif
  output logic [0:BWIDTH-1] lin_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy
);

  if (BWIDTH != 32) begin : g_bad_width
    $error("sms4_lin_iter: only BWIDTH=32 is supported");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state, state_nxt;
  logic [0:BWIDTH-1] rot, rot_nxt;
  logic [0:BWIDTH-1] acc, acc_nxt;
  logic [0:BWIDTH-1] lin_out_nxt;
  logic [0:BWIDTH-1] rot_shift;
  logic [1:0]        step, step_nxt;
  logic [4:0]        amt;
  logic              last_step;
  logic              out_valid_nxt;
  logic              key_q;

  // Bit 0 is the MSB, so a numeric left shift moves bit i+n into bit i.
  function automatic logic [0:BWIDTH-1] rotl(input logic [0:BWIDTH-1] v, input logic [4:0] n);
    return (v << n) | (v >> (BWIDTH - int'(n)));
  endfunction

`ifdef SMS4_LIN_KEY_EN
  logic key_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      key_q <= 1'b0;
    end else begin
      key_q <= key_nxt;
    end
  end

  always_comb begin
    key_nxt = key_q;
    if (state == IDLE && in_valid) begin
      key_nxt = key_mode;
    end
  end
`else
  assign key_q = 1'b0;
`endif

  // Incremental rotations; each step's amount is relative to the previous rotate value.
  always_comb begin
    amt       = 5'd6;
    last_step = 1'b0;
    if (key_q) begin
      amt       = (step == 2'd0) ? 5'd13 : 5'd10;
      last_step = (step == 2'd1);
    end else begin
      case (step)
        2'd0:    amt = 5'd2;
        2'd1:    amt = 5'd8;
        2'd2:    amt = 5'd8;
        default: amt = 5'd6;
      endcase
      last_step = (step == 2'd3);
    end
  end

  assign rot_shift = rotl(rot, amt);

  always_comb begin
    state_nxt     = state;
    rot_nxt       = rot;
    acc_nxt       = acc;
    step_nxt      = step;
    lin_out_nxt   = lin_out;
    out_valid_nxt = out_valid;
    case (state)
      IDLE: begin
        if (in_valid) begin
          rot_nxt   = lin_in;
          acc_nxt   = lin_in;
          step_nxt  = 2'd0;
          state_nxt = RUN;
        end
      end
      RUN: begin
        rot_nxt  = rot_shift;
        acc_nxt  = acc ^ rot_shift;
        step_nxt = step + 2'd1;
        if (last_step) begin
          lin_out_nxt   = acc ^ rot_shift;
          out_valid_nxt = 1'b1;
          state_nxt     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_nxt = 1'b0;
          state_nxt     = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rot       <= '0;
      acc       <= '0;
      step      <= 2'd0;
      lin_out   <= '0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      rot       <= rot_nxt;
      acc       <= acc_nxt;
      step      <= step_nxt;
      lin_out   <= lin_out_nxt;
      out_valid <= out_valid_nxt;
    end
  end

  // Gated by rst so nothing looks acceptable during the reset cycle.
  assign in_ready = (state == IDLE) && !rst;
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_sms4_lin_iter.sv
// Self-checking bench for sms4_lin_iter: scoreboard of reference transforms, one task per scenario.
module tb_sms4_lin_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic [0:31] lin_in;
  logic        in_valid;
  logic        in_ready;
  logic [0:31] lin_out;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
`ifdef SMS4_LIN_KEY_EN
  logic        key_mode;
`endif

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  sms4_lin_iter #(.BWIDTH(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .lin_in   (lin_in),
    .in_valid (in_valid),
    .in_ready (in_ready),
`ifdef SMS4_LIN_KEY_EN
    .key_mode (key_mode),
`endif
    .lin_out  (lin_out),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy     (busy)
  );

  function automatic logic [31:0] rl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [31:0] model_l(input logic [31:0] b);
    return b ^ rl(b, 2) ^ rl(b, 10) ^ rl(b, 18) ^ rl(b, 24);
  endfunction

  function automatic logic [31:0] model_k(input logic [31:0] b);
    return b ^ rl(b, 13) ^ rl(b, 23);
  endfunction

  // Presents one word, pushes its expected result, returns at the negedge after the accept edge.
  task automatic send_word(input logic [31:0] w, input bit km);
    int n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("[TB] FAIL send_timeout in_ready=%b required 1", in_ready);
    end
    lin_in   = w;
    in_valid = 1'b1;
`ifdef SMS4_LIN_KEY_EN
    key_mode = km;
`endif
    exp_q.push_back(km ? model_k(w) : model_l(w));
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Edge index (accept edge = 1) at which out_valid was first seen; 30 on timeout.
  task automatic wait_out(output int edges);
    edges = 1;
    while (!out_valid && edges < 30) begin
      @(negedge clk);
      edges++;
    end
  endtask

  task automatic pop_exp(output logic [31:0] e);
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else e = 'x;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; lin_in = '0;
`ifdef SMS4_LIN_KEY_EN
    key_mode = 1'b0;
`endif
    repeat (2) @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_in_ready got=%b exp=0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (lin_out !== 32'h0) begin errors++; $display("[TB] FAIL reset_lin_out got=%h exp=0", lin_out); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_basic();
    int e;
    logic [31:0] exp;
    out_ready = 1'b1;
    send_word(32'h00000001, 1'b0);
    checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("[TB] FAIL run_flags busy=%b in_ready=%b exp busy=1 in_ready=0", busy, in_ready); end
    wait_out(e);
    checks++; if (e !== 5) begin errors++; $display("[TB] FAIL basic_latency got=%0d exp=5", e); end
    checks++; if (lin_out !== 32'h01040405) begin errors++; $display("[TB] FAIL basic_vector got=%h exp=01040405", lin_out); end
    pop_exp(exp);
    checks++; if (lin_out !== exp) begin errors++; $display("[TB] FAIL basic_sb got=%h exp=%h", lin_out, exp); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_one_cycle out_valid=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL basic_back_idle in_ready=%b exp=1", in_ready); end
    checks++; if (lin_out !== 32'h01040405) begin errors++; $display("[TB] FAIL basic_kept got=%h exp=01040405", lin_out); end
  endtask

  task automatic test_hold();
    int e;
    logic [31:0] exp;
    out_ready = 1'b0;
    send_word(32'h80000000, 1'b0);
    wait_out(e);
    checks++; if (e !== 5) begin errors++; $display("[TB] FAIL hold_latency got=%0d exp=5", e); end
    in_valid = 1'b1;
    lin_in   = 32'h12345678;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (lin_out !== 32'h80820202 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("[TB] FAIL hold_stable cyc=%0d lin_out=%h out_valid=%b in_ready=%b exp 80820202/1/0", i, lin_out, out_valid, in_ready);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    pop_exp(exp);
    checks++; if (lin_out !== exp) begin errors++; $display("[TB] FAIL hold_sb got=%h exp=%h", lin_out, exp); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("[TB] FAIL hold_release out_valid=%b in_ready=%b busy=%b exp 0/1/0", out_valid, in_ready, busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] words[2];
    int acc_cyc[2];
    int idx = 0;
    int got = 0;
    bit accepted_prev = 1'b0;
    logic [31:0] exp;
    words[0] = 32'hFFFFFFFF;
    words[1] = 32'h00000000;
    acc_cyc[0] = -100;
    acc_cyc[1] = 100;
    out_ready = 1'b1;
    lin_in    = words[0];
    in_valid  = 1'b1;
    for (int c = 0; c < 40 && got < 2; c++) begin
      if (accepted_prev) begin
        idx++;
        if (idx < 2) lin_in = words[idx];
        else in_valid = 1'b0;
        accepted_prev = 1'b0;
      end
      if (out_valid && out_ready) begin
        pop_exp(exp);
        checks++; if (lin_out !== exp) begin errors++; $display("[TB] FAIL b2b_result%0d got=%h exp=%h", got, lin_out, exp); end
        got++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model_l(lin_in));
        acc_cyc[idx] = c;
        accepted_prev = 1'b1;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks++; if (got !== 2) begin errors++; $display("[TB] FAIL b2b_count got=%0d exp=2", got); end
    checks++; if (acc_cyc[1] - acc_cyc[0] !== 6) begin errors++; $display("[TB] FAIL b2b_spacing got=%0d exp=6", acc_cyc[1] - acc_cyc[0]); end
  endtask

  task automatic test_reset_mid();
    int e;
    bit seen = 1'b0;
    logic [31:0] exp;
    out_ready = 1'b1;
    send_word(32'h00000001, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || lin_out !== 32'h0) begin
      errors++; $display("[TB] FAIL midrst_state in_ready=%b out_valid=%b busy=%b lin_out=%h exp 0/0/0/0", in_ready, out_valid, busy, lin_out);
    end
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL midrst_in_ready got=%b exp=1", in_ready); end
    for (int i = 0; i < 8; i++) begin
      if (out_valid) seen = 1'b1;
      @(negedge clk);
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("[TB] FAIL midrst_no_output seen=%b exp=0", seen); end
    send_word(32'hDEADBEEF, 1'b0);
    wait_out(e);
    checks++; if (e !== 5) begin errors++; $display("[TB] FAIL midrst_latency got=%0d exp=5", e); end
    pop_exp(exp);
    checks++; if (lin_out !== exp) begin errors++; $display("[TB] FAIL midrst_next got=%h exp=%h", lin_out, exp); end
    @(negedge clk);
  endtask

  task automatic test_sample_once();
    int e = 1;
    logic [31:0] exp;
    out_ready = 1'b1;
    send_word($urandom, 1'b0);
    while (!out_valid && e < 30) begin
      lin_in   = $urandom;
      in_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
      e++;
    end
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL sample_timeout out_valid=%b exp=1", out_valid); end
    pop_exp(exp);
    checks++; if (lin_out !== exp) begin errors++; $display("[TB] FAIL sample_once got=%h exp=%h", lin_out, exp); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL sample_idle busy=%b exp=0", busy); end
  endtask

  task automatic test_random();
    int e;
    logic [31:0] exp;
    for (int k = 0; k < 5; k++) begin
      out_ready = 1'b0;
      send_word($urandom, 1'b0);
      wait_out(e);
      checks++; if (e !== 5) begin errors++; $display("[TB] FAIL rand_latency%0d got=%0d exp=5", k, e); end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      out_ready = 1'b1;
      pop_exp(exp);
      checks++; if (lin_out !== exp || out_valid !== 1'b1) begin
        errors++; $display("[TB] FAIL rand_result%0d got=%h valid=%b exp=%h", k, lin_out, out_valid, exp);
      end
      @(negedge clk);
    end
    out_ready = 1'b0;
  endtask

`ifdef SMS4_LIN_KEY_EN
  task automatic test_key();
    int e;
    logic [31:0] exp;
    out_ready = 1'b1;
    send_word(32'h00000001, 1'b1);
    key_mode = 1'b0;
    wait_out(e);
    checks++; if (e !== 3) begin errors++; $display("[TB] FAIL key_latency got=%0d exp=3", e); end
    checks++; if (lin_out !== 32'h00802001) begin errors++; $display("[TB] FAIL key_vector got=%h exp=00802001", lin_out); end
    pop_exp(exp);
    checks++; if (lin_out !== exp) begin errors++; $display("[TB] FAIL key_sb got=%h exp=%h", lin_out, exp); end
    @(negedge clk);
    send_word(32'h00000001, 1'b0);
    key_mode = 1'b1;
    wait_out(e);
    checks++; if (e !== 5) begin errors++; $display("[TB] FAIL key0_latency got=%0d exp=5", e); end
    checks++; if (lin_out !== 32'h01040405) begin errors++; $display("[TB] FAIL key0_vector got=%h exp=01040405", lin_out); end
    pop_exp(exp);
    @(negedge clk);
    key_mode = 1'b0;
  endtask
`endif

  initial begin
    #200000;
    $display("[TB] FAIL watchdog simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    test_sample_once();
    test_random();
`ifdef SMS4_LIN_KEY_EN
    test_key();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
